// File: rtl/tile_pkg.sv
// tile_pkg: shared state encoding and default widths for the tile match engine.
package tile_pkg;
    typedef enum logic [1:0] {IDLE, ONE, SHOW, DONE} state_t;
    localparam int IDX_W   = 4;
    localparam int VAL_W   = 3;
    localparam int SCORE_W = 8;
endpackage

// File: rtl/tile_match_engine_if.sv
// tile_match_engine_if: pick/board inputs and board-status outputs of the match engine.
// Ports: master drives pick, pick_idx, board and observes status.
//        slave (the engine) observes inputs and drives revealed, matched, score,
//        misses, busy, match_pulse, miss_pulse, game_over.
interface tile_match_engine_if import tile_pkg::*; #(
    parameter int NUM_TILES = 16,
    parameter int IDX_W     = tile_pkg::IDX_W,
    parameter int VAL_W     = tile_pkg::VAL_W,
    parameter int SCORE_W   = tile_pkg::SCORE_W
);
    logic                       pick;
    logic [IDX_W-1:0]           pick_idx;
    logic [NUM_TILES*VAL_W-1:0] board;
    logic [NUM_TILES-1:0]       revealed;
    logic [NUM_TILES-1:0]       matched;
    logic [SCORE_W-1:0]         score;
    logic [SCORE_W-1:0]         misses;
    logic                       busy;
    logic                       match_pulse;
    logic                       miss_pulse;
    logic                       game_over;

    modport master (
        output pick, pick_idx, board,
        input  revealed, matched, score, misses, busy, match_pulse, miss_pulse, game_over
    );
    modport slave (
        input  pick, pick_idx, board,
        output revealed, matched, score, misses, busy, match_pulse, miss_pulse, game_over
    );
endinterface

// File: rtl/tile_match_engine_show_timer.sv
// show_timer: loadable down-counter timing the miss display.
// Ports: CLOCK_50 clock, reset sync active-high, load restarts the count,
//        expire is a one-cycle pulse SHOW_CYCLES cycles after load.
module show_timer #(
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic load,
    output logic expire
);
    localparam int CW = $clog2(SHOW_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= CW'(SHOW_CYCLES);
        else if (count != '0)
            count <= count - CW'(1);
    end

    // count reaches 1 in the last display cycle, so the engine leaves SHOW on that edge
    assign expire = count == CW'(1);
endmodule

// File: rtl/tile_match_engine.sv
// tile_match_engine: pair-matching core tracking face-up and matched tiles, score and misses.
// Ports: CLOCK_50 clock, reset sync active-high, bus (tile_match_engine_if.slave) carrying
//        pick/pick_idx/board in and revealed/matched/score/misses/busy/pulses/game_over out.
// Config: define TILE_MISS_COUNT_EN to implement the misses counter; otherwise misses is 0.
module tile_match_engine import tile_pkg::*; #(
    parameter int NUM_TILES   = 16,
    parameter int IDX_W       = tile_pkg::IDX_W,
    parameter int VAL_W       = tile_pkg::VAL_W,
    parameter int SCORE_W     = tile_pkg::SCORE_W,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    tile_match_engine_if.slave   bus
);
    // tile index width actually needed to address the board; pick_idx may be wider
    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    state_t          state;
    logic [TW-1:0]   first_idx;
    logic [TW-1:0]   tidx;
    logic [NUM_TILES-1:0] sel;
    logic [NUM_TILES-1:0] matched_next;
    logic            in_range;
    logic            valid;
    logic            same;
    logic            load;
    logic            expire;

    assign tidx         = bus.pick_idx[TW-1:0];
    assign in_range     = {1'b0, bus.pick_idx} < (IDX_W + 1)'(NUM_TILES);
    assign sel          = {{(NUM_TILES - 1){1'b0}}, 1'b1} << tidx;
    assign valid        = bus.pick && in_range && !bus.matched[tidx] && !bus.revealed[tidx]
                          && (state == IDLE || state == ONE);
    assign same         = bus.board[tidx * VAL_W +: VAL_W] == bus.board[first_idx * VAL_W +: VAL_W];
    // in ONE exactly the first tile is revealed, so revealed|sel is the completed pair
    assign matched_next = bus.matched | bus.revealed | sel;
    assign load         = valid && state == ONE && !same;

    show_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_timer (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .load     (load),
        .expire   (expire)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            first_idx       <= '0;
            bus.revealed    <= '0;
            bus.matched     <= '0;
            bus.score       <= '0;
            bus.busy        <= 1'b0;
            bus.match_pulse <= 1'b0;
            bus.miss_pulse  <= 1'b0;
            bus.game_over   <= 1'b0;
        end else begin
            bus.match_pulse <= 1'b0;
            bus.miss_pulse  <= 1'b0;
            case (state)
                IDLE: if (valid) begin
                    bus.revealed <= sel;
                    first_idx    <= tidx;
                    state        <= ONE;
                end
                ONE: if (valid) begin
                    if (same) begin
                        bus.matched     <= matched_next;
                        bus.revealed    <= '0;
                        bus.match_pulse <= 1'b1;
                        if (bus.score != '1)
                            bus.score <= bus.score + SCORE_W'(1);
                        bus.game_over   <= &matched_next;
                        state           <= &matched_next ? DONE : IDLE;
                    end else begin
                        bus.revealed   <= bus.revealed | sel;
                        bus.miss_pulse <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= SHOW;
                    end
                end
                SHOW: if (expire) begin
                    bus.revealed <= '0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: ;
            endcase
        end
    end

`ifdef TILE_MISS_COUNT_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            bus.misses <= '0;
        else if (load && bus.misses != '1)
            bus.misses <= bus.misses + SCORE_W'(1);
    end
`else
    assign bus.misses = '0;
`endif
endmodule

// File: tb/tb_tile_match_engine.sv
// tb_tile_match_engine: directed and random picks checked against a pair-game reference model.
module tb_tile_match_engine;
    localparam int NT = 16;
    localparam int IW = 5;
    localparam int VW = 3;
    localparam int SW = 8;
    localparam int SC = 4;

    logic CLOCK_50 = 1'b0;
    logic reset;

    tile_match_engine_if #(.NUM_TILES(NT), .IDX_W(IW), .VAL_W(VW), .SCORE_W(SW)) bus ();

    tile_match_engine #(
        .NUM_TILES(NT), .IDX_W(IW), .VAL_W(VW), .SCORE_W(SW), .SHOW_CYCLES(SC)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus.slave)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;
    int vals [NT] = '{3, 2, 2, 7, 7, 3, 0, 0, 1, 1, 4, 4, 5, 5, 6, 6};
    bit m_mat [NT];
    int up [$];
    int m_score, m_misses, show_left;
    bit m_mp, m_xp;
`ifdef TILE_MISS_COUNT_EN
    localparam int MISS_ON = 1;
`else
    localparam int MISS_ON = 0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit all_matched();
        foreach (m_mat[i]) if (!m_mat[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Game rules: at most two tiles face up; a differing pair stays visible for SC cycles.
    function automatic void model(input bit r, input bit p, input int idx);
        m_mp = 1'b0;
        m_xp = 1'b0;
        if (r) begin
            foreach (m_mat[i]) m_mat[i] = 1'b0;
            up.delete();
            m_score = 0;
            m_misses = 0;
            show_left = 0;
            return;
        end
        if (show_left > 0) begin
            show_left--;
            if (show_left == 0) up.delete();
            return;
        end
        if (!p || idx >= NT || all_matched() || m_mat[idx]) return;
        foreach (up[k]) if (up[k] == idx) return;
        if (up.size() == 0) begin
            up.push_back(idx);
        end else if (vals[up[0]] == vals[idx]) begin
            m_mat[up[0]] = 1'b1;
            m_mat[idx] = 1'b1;
            up.delete();
            if (m_score < 255) m_score++;
            m_mp = 1'b1;
        end else begin
            up.push_back(idx);
            if (MISS_ON != 0 && m_misses < 255) m_misses++;
            m_xp = 1'b1;
            show_left = SC;
        end
    endfunction

    task automatic check_all();
        logic [NT-1:0] er, em;
        er = '0;
        em = '0;
        foreach (up[k]) er[up[k]] = 1'b1;
        foreach (m_mat[i]) em[i] = m_mat[i];
        check("revealed", bus.revealed, er);
        check("matched", bus.matched, em);
        check("score", bus.score, m_score);
        check("misses", bus.misses, m_misses);
        check("busy", bus.busy, show_left > 0);
        check("match_pulse", bus.match_pulse, m_mp);
        check("miss_pulse", bus.miss_pulse, m_xp);
        check("game_over", bus.game_over, all_matched());
    endtask

    task automatic tick(input bit r, input bit p, input int idx);
        reset = r;
        bus.pick = p;
        bus.pick_idx = IW'(idx);
        @(posedge CLOCK_50);
        model(r, p, idx);
        #1;
        check_all();
    endtask

    int pairs [16] = '{0, 5, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

    initial begin
        reset = 1'b1;
        bus.pick = 1'b0;
        bus.pick_idx = '0;
        foreach (vals[i]) bus.board[i * VW +: VW] = VW'(vals[i]);

        tick(1, 0, 0);
        check("rst_revealed", bus.revealed, 16'h0000);
        check("rst_score", bus.score, 0);

        tick(0, 1, 0);
        tick(0, 1, 5);
        check("d_match_matched", bus.matched, 16'h0021);
        check("d_match_score", bus.score, 1);
        check("d_match_pulse", bus.match_pulse, 1);
        tick(0, 0, 0);
        check("d_match_pulse_drop", bus.match_pulse, 0);

        tick(0, 1, 1);
        tick(0, 1, 3);
        check("d_miss_revealed", bus.revealed, 16'h000A);
        check("d_miss_busy", bus.busy, 1);
        check("d_misses", bus.misses, MISS_ON);
        tick(0, 1, 5);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("d_busy_last", bus.busy, 1);
        tick(0, 0, 0);
        check("d_miss_cleared", bus.revealed, 16'h0000);
        check("d_busy_drop", bus.busy, 0);

        tick(0, 1, 3);
        tick(0, 1, 3);
        check("d_dup_pick", bus.revealed, 16'h0008);
        tick(0, 1, 16);
        check("d_oob_pick", bus.revealed, 16'h0008);
        tick(0, 1, 4);
        check("d_second_score", bus.score, 2);

        tick(1, 0, 0);
        foreach (pairs[i]) tick(0, 1, pairs[i]);
        check("d_full_score", bus.score, 8);
        check("d_full_over", bus.game_over, 1);
        check("d_full_pulse", bus.match_pulse, 1);
        tick(0, 1, 2);
        check("d_done_ignore", bus.score, 8);

        tick(1, 0, 0);
        tick(0, 1, 1);
        tick(0, 1, 3);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check("d_rst_show_busy", bus.busy, 0);
        check("d_rst_show_rev", bus.revealed, 16'h0000);
        tick(0, 1, 7);
        check("d_after_rst_pick", bus.revealed, 16'h0080);

        tick(1, 1, 6);
        check("d_rst_pick", bus.revealed, 16'h0000);

        repeat (800) begin
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 17)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
